// File: rtl/sensor_mon_pkg.sv
// Shared types and defaults for the sensor fault monitor.
// State encoding, default masks and the fault condition helper.
package sensor_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUAL  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam int unsigned NUM_SENSORS_DEF = 4;
    localparam int unsigned PERSIST_DEF     = 3;
    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned ANCHOR_IDX_DEF  = 1;

    localparam logic [31:0] CRIT_MASK_DEF = 32'h0000_0001;
    localparam logic [31:0] DEP_MASK_DEF  = 32'h0000_000C;

    // A critical sensor faults alone; the anchor only faults
    // when at least one of its dependent sensors is also active.
    function automatic logic fault_cond(
        input logic [31:0] s,
        input logic [31:0] crit,
        input logic [31:0] dep,
        input logic [4:0]  anchor
    );
        logic crit_hit;
        logic pair_hit;
        crit_hit = |(s & crit);
        pair_hit = s[anchor] & (|(s & dep));
        return crit_hit | pair_hit;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Width is parametrised; reset clears both stages.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back stages give the first stage time to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sensor_monitor.sv
// Sensor fault monitor: synchronise, qualify for PERSIST cycles, latch.
// Optional fault event counter enabled by SENSOR_MON_EVTCNT_EN.
module sensor_monitor
    import sensor_mon_pkg::*;
#(
    parameter int unsigned NUM_SENSORS = NUM_SENSORS_DEF,
    parameter int unsigned PERSIST     = PERSIST_DEF,
    parameter logic [31:0] CRIT_MASK   = CRIT_MASK_DEF,
    parameter int unsigned ANCHOR_IDX  = ANCHOR_IDX_DEF,
    parameter logic [31:0] DEP_MASK    = DEP_MASK_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic                   clear,
    output logic                   error,
    output logic                   qualifying,
    output logic [NUM_SENSORS-1:0] fault_vec,
    output logic [CNT_W-1:0]       fault_cnt
);

    localparam int unsigned PW = $clog2(PERSIST + 1);
    localparam logic [PW-1:0] PLAST = PW'(PERSIST - 1);
    localparam logic [PW-1:0] PONE  = PW'(1);
    localparam logic [4:0]    AIDX  = 5'(ANCHOR_IDX);
    localparam bit            ONE_SHOT = (PERSIST == 1);

    logic [NUM_SENSORS-1:0] sens_s;
    logic [31:0]            sens_w;
    logic                   raw;
    logic                   enter;
    state_t                 state;
    logic [PW-1:0]          pcnt;

    sync_2ff #(
        .W (NUM_SENSORS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sensors),
        .q   (sens_s)
    );

    // Fault condition on the synchronised snapshot.
    always_comb begin
        sens_w = 32'(sens_s);
        raw    = fault_cond(sens_w, CRIT_MASK, DEP_MASK, AIDX);
    end

    // Edge that moves the FSM into FAULT; shared with the event counter.
    always_comb begin
        enter = 1'b0;
        unique case (state)
            IDLE:    enter = raw & ONE_SHOT;
            QUAL:    enter = raw & (pcnt == PLAST);
            default: enter = 1'b0;
        endcase
    end

    // Qualification FSM with registered outputs and fault snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pcnt       <= '0;
            error      <= 1'b0;
            qualifying <= 1'b0;
            fault_vec  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enter) begin
                        state      <= FAULT;
                        pcnt       <= '0;
                        error      <= 1'b1;
                        fault_vec  <= sens_s;
                    end else if (raw) begin
                        state      <= QUAL;
                        pcnt       <= PONE;
                        qualifying <= 1'b1;
                    end else begin
                        pcnt       <= '0;
                    end
                end
                QUAL: begin
                    if (!raw) begin
                        state      <= IDLE;
                        pcnt       <= '0;
                        qualifying <= 1'b0;
                    end else if (enter) begin
                        state      <= FAULT;
                        pcnt       <= '0;
                        qualifying <= 1'b0;
                        error      <= 1'b1;
                        fault_vec  <= sens_s;
                    end else begin
                        pcnt       <= pcnt + PONE;
                    end
                end
                FAULT: begin
                    // A clear while the condition persists is dropped.
                    if (clear && !raw) begin
                        state      <= IDLE;
                        pcnt       <= '0;
                        error      <= 1'b0;
                        fault_vec  <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pcnt       <= '0;
                    error      <= 1'b0;
                    qualifying <= 1'b0;
                    fault_vec  <= '0;
                end
            endcase
        end
    end

`ifdef SENSOR_MON_EVTCNT_EN
    logic [CNT_W-1:0] evt_cnt;

    // Saturating count of FAULT entries; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (enter && (evt_cnt != '1)) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end

    assign fault_cnt = evt_cnt;
`else
    assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_sensor_monitor.sv
// Self-checking bench for sensor_monitor (default parameters).
// Vector table, hand sequences and random stimulus vs. a reference model.
module tb_sensor_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] sensors;
    logic       clear;
    logic       error;
    logic       qualifying;
    logic [3:0] fault_vec;
    logic [7:0] fault_cnt;

    int checks = 0;
    int errors = 0;

    sensor_monitor u_dut (
        .clk        (clk),
        .rst        (rst),
        .sensors    (sensors),
        .clear      (clear),
        .error      (error),
        .qualifying (qualifying),
        .fault_vec  (fault_vec),
        .fault_cnt  (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the condition must be seen on PERSIST
    // consecutive edges, delayed two edges by synchronisation.
    localparam int PERSIST = 3;
    logic [3:0] m_s1, m_s2, m_vec;
    bit         m_err;
    int         m_run, m_cnt;

    function automatic bit m_raw(input logic [3:0] s);
        return s[0] || (s[1] && (s[2] || s[3]));
    endfunction

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_vec = '0;
        m_err = 0; m_run = 0; m_cnt = 0;
    endtask

    task automatic m_edge(input logic [3:0] s, input logic c);
        bit r;
        r = m_raw(m_s2);
        if (m_err) begin
            if (c && !r) begin
                m_err = 0;
                m_vec = '0;
                m_run = 0;
            end
        end else if (r) begin
            m_run++;
            if (m_run >= PERSIST) begin
                m_err = 1;
                m_vec = m_s2;
                m_run = 0;
                if (m_cnt < 255) m_cnt++;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = s;
    endtask

    function automatic int exp_cnt();
`ifdef SENSOR_MON_EVTCNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_qual"}, 32'(qualifying), 32'd0);
        chk({tag, "_vec"}, 32'(fault_vec), 32'd0);
        chk({tag, "_cnt"}, 32'(fault_cnt), 32'd0);
    endtask

    // One clock: drive, let the edge happen, compare at negedge.
    task automatic step(input logic [3:0] s, input logic c);
        sensors = s;
        clear   = c;
        @(posedge clk);
        m_edge(s, c);
        @(negedge clk);
        chk("m_err", 32'(error), 32'(m_err));
        chk("m_qual", 32'(qualifying), 32'(!m_err && m_run > 0));
        chk("m_vec", 32'(fault_vec), 32'(m_vec));
        chk("m_cnt", 32'(fault_cnt), 32'(exp_cnt()));
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_outs_zero({tag, "_async"});
        m_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_outs_zero({tag, "_held"});
        rst = 1'b0;
    endtask

    task automatic latency(input string tag);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(4'b0001, 1'b0);
            n++;
            if (error) hit = 1;
        end
        chk({tag, "_latency"}, 32'(n), 32'd5);
    endtask

    typedef struct {
        logic [3:0] s;
        logic       c;
        logic       e;
        logic       q;
        logic [3:0] v;
    } vec_t;

    vec_t tbl[29];

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[2]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[3]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[4]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 4'b0001};
        tbl[5]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001};
        tbl[6]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0001};
        tbl[7]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0001};
        tbl[8]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[9]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[10] = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[14] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[15] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[16] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[17] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[18] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[19] = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[20] = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[21] = '{4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[22] = '{4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[23] = '{4'b0110, 1'b0, 1'b1, 1'b0, 4'b0110};
        tbl[24] = '{4'b1010, 1'b1, 1'b1, 1'b0, 4'b0110};
        tbl[25] = '{4'b1010, 1'b0, 1'b1, 1'b0, 4'b0110};
        tbl[26] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0110};
        tbl[27] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0110};
        tbl[28] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};

        rst = 1'b1;
        sensors = '0;
        clear = 1'b0;
        m_reset();
        #12;
        chk_outs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].s, tbl[i].c);
            chk($sformatf("tbl_err[%0d]", i), 32'(error), 32'(tbl[i].e));
            chk($sformatf("tbl_qual[%0d]", i), 32'(qualifying), 32'(tbl[i].q));
            chk($sformatf("tbl_vec[%0d]", i), 32'(fault_vec), 32'(tbl[i].v));
        end

        for (int i = 0; i < 20; i++) begin
            step(4'b0010, 1'b0);
            chk("anchor_err", 32'(error), 32'd0);
            chk("anchor_qual", 32'(qualifying), 32'd0);
        end

        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
        chk("pre_rst_qual", 32'(qualifying), 32'd1);
        pulse_reset("rst_qual");
        latency("after_qual_rst");
        chk("pre_rst_fault", 32'(error), 32'd1);
        pulse_reset("rst_fault");
        latency("after_fault_rst");

        for (int seg = 0; seg < 60; seg++) begin
            logic [3:0] pat;
            int len;
            pat = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++)
                step(pat, 1'($urandom_range(0, 3) == 0));
        end

        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        chk("drain_err", 32'(error), 32'd0);

        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 5; k++) step(4'b0001, 1'b0);
            step(4'b0000, 1'b0);
            step(4'b0000, 1'b0);
            step(4'b0000, 1'b1);
        end
`ifdef SENSOR_MON_EVTCNT_EN
        chk("evt_cnt_sat", 32'(fault_cnt), 32'd255);
`else
        chk("evt_cnt_tied", 32'(fault_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
